// File: rtl/cpu_control_sequencer.sv
// Hard-wired control sequencer: two-cycle byte fetch into IR, decode, multi-step execute for
// BRA / MOVL / LD / ADD / HLT. Only the step counter and halt flag are stateful.
module cpu_control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    output logic [2:0]  SeqCnt,
    output logic        Halted,
    output logic        IR_Write,
    output logic        IR_LH,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic        DR_E,
    output logic [1:0]  DR_FunSel,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [3:0]  RF_RegSel,
    output logic [2:0]  RF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_FunSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic        MuxDSel,
    output logic [1:0]  MuxCSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [3:0]  RF_ScrSel
);

    typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7} step_e;

    localparam logic [5:0] OpBra  = 6'h00;
    localparam logic [5:0] OpMovl = 6'h11;
    localparam logic [5:0] OpLd   = 6'h12;
    localparam logic [5:0] OpAdd  = 6'h14;
    localparam logic [5:0] OpHlt  = 6'h15;

    step_e      seq_q, seq_d;
    logic       halted_q, halted_d;
    logic [5:0] opcode;
    logic [1:0] rsel;
    logic [3:0] rsel_onehot;
    logic       unused_imm;

    assign opcode      = IROut[15:10];
    assign rsel        = IROut[9:8];
    assign rsel_onehot = 4'b1000 >> rsel;
    // The immediate feeds the datapath directly through MuxA/MuxB, never the sequencer.
    assign unused_imm  = ^IROut[7:0];

    assign SeqCnt      = seq_q;
    assign Halted      = halted_q;
    assign MuxDSel     = 1'b0;
    assign MuxCSel     = 2'b00;
    assign ARF_OutCSel = 2'b00;
    assign RF_ScrSel   = 4'b0000;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            seq_q    <= StT0;
            halted_q <= 1'b0;
        end else begin
            seq_q    <= seq_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        seq_d    = seq_q;
        halted_d = halted_q;
        if (halted_q) begin
            seq_d = StT0;
        end else begin
            case (seq_q)
                StT0: seq_d = StT1;
                StT1: seq_d = StT2;
                StT2: begin
                    seq_d = (opcode == OpLd) ? StT3 : StT0;
                    if (opcode == OpHlt) halted_d = 1'b1;
                end
                StT3, StT4, StT5, StT6: seq_d = step_e'(seq_q + 3'd1);
                default: seq_d = StT0;
            endcase
        end
    end

    always_comb begin
        IR_Write    = 1'b0;
        IR_LH       = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        DR_E        = 1'b0;
        DR_FunSel   = 2'b00;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_FunSel   = 3'b000;
        ARF_RegSel  = 3'b000;
        ARF_FunSel  = 2'b00;
        ARF_OutDSel = 2'b00;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        // Outputs stay idle while reset is held, even though the counter sits at T0.
        if (Reset && !halted_q) begin
            case (seq_q)
                StT0, StT1: begin
                    ARF_OutDSel = 2'b00;
                    Mem_CS      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (seq_q == StT1);
                    ARF_RegSel  = 3'b100;
                    ARF_FunSel  = 2'b01;
                end
                StT2: begin
                    case (opcode)
                        OpBra: begin
                            MuxBSel    = 2'b11;
                            ARF_RegSel = 3'b100;
                            ARF_FunSel = 2'b10;
                        end
                        OpMovl: begin
                            MuxASel   = 2'b11;
                            RF_RegSel = rsel_onehot;
                            RF_FunSel = 3'b010;
                        end
                        OpLd: begin
                            MuxBSel    = 2'b11;
                            ARF_RegSel = 3'b010;
                            ARF_FunSel = 2'b10;
                        end
                        OpAdd: begin
                            RF_OutASel = {1'b0, rsel};
                            RF_OutBSel = 3'b000;
                            ALU_FunSel = 5'b10100;
                            ALU_WF     = 1'b1;
                            MuxASel    = 2'b00;
                            RF_RegSel  = rsel_onehot;
                            RF_FunSel  = 3'b010;
                        end
                        default: ;
                    endcase
                end
                StT3, StT4, StT5, StT6: begin
                    ARF_OutDSel = 2'b10;
                    Mem_CS      = 1'b0;
                    DR_E        = 1'b1;
                    DR_FunSel   = (seq_q == StT3) ? 2'b01 : 2'b10;
                    if (seq_q != StT6) begin
                        ARF_RegSel = 3'b010;
                        ARF_FunSel = 2'b01;
                    end
                end
                StT7: begin
                    MuxASel   = 2'b10;
                    RF_RegSel = rsel_onehot;
                    RF_FunSel = 3'b010;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Hard-wired control unit for the ALU-system datapath (register file, address register file, ALU, data register, instruction register, byte-wide memory). It drives a two-cycle byte fetch into the instruction register, decodes the loaded instruction, and steps a sequence counter through a multi-cycle execute. It emits every datapath select and enable each cycle. It covers a five-instruction subset: branch, move-immediate, 32-bit load, add and halt.

## Interface
- Parameters: none; all encodings are fixed and listed under Operation.
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; clears sequence counter and halt flag
- IROut  in  16  instruction register contents; fields [15:10] opcode, [9:8] RSel (R1..R4), [7:0] imm/address
- SeqCnt  out  3  current micro-step T0..T7
- Halted  out  1  high after HLT executes
- IR_Write, IR_LH  out  1 each  instruction register write enable; half select (0 = low byte)
- Mem_CS, Mem_WR  out  1 each  memory chip select (active-low); write (always 0 in this subset)
- DR_E  out  1  data register enable
- DR_FunSel  out  2  01 = load byte, upper bits cleared; 10 = shift left 8, load byte into [7:0]
- MuxASel, MuxBSel  out  2 each  00 ALU, 01 ARF OutC, 10 DR, 11 IROut[7:0]
- RF_OutASel, RF_OutBSel  out  3 each  000..011 = R1..R4
- RF_RegSel  out  4  active-high one-hot write enable, [3]=R1 .. [0]=R4
- RF_FunSel  out  3  010 = load
- ARF_RegSel  out  3  active-high, [2]=PC, [1]=AR, [0]=SP
- ARF_FunSel  out  2  01 = increment, 10 = load
- ARF_OutDSel  out  2  00 = PC, 10 = AR (memory address)
- ALU_FunSel  out  5  10100 = A+B, 32-bit
- ALU_WF  out  1  flag write enable
- Top level ties off these datapath controls: MuxDSel=0, MuxCSel=00, ARF_OutCSel=00, RF_ScrSel=0000.

## Operation
- Idle outputs: IR_Write=0, Mem_CS=1, DR_E=0, ALU_WF=0, RF_RegSel=0000, ARF_RegSel=000. All other selects are 0.
- All outputs decode combinationally from SeqCnt, Halted and IROut. Only SeqCnt and Halted are registered.
- T0 (fetch low): ARF_OutDSel=00, Mem_CS=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01 (PC++).
- T1 (fetch high): same as T0 with IR_LH=1. IR holds the full instruction from T2 onward.
- Opcode 0x00 BRA, at T2: MuxBSel=11, ARF_RegSel=100, ARF_FunSel=10, so PC <= imm. Next step is T0.
- Opcode 0x11 MOVL, at T2: MuxASel=11, RF_RegSel=onehot(RSel), RF_FunSel=010, so Rx <= zero-extended imm. Next step is T0.
- Opcode 0x12 LD, big-endian, 32-bit:
  - T2: AR <= imm (MuxBSel=11, ARF_RegSel=010, ARF_FunSel=10).
  - T3..T6: ARF_OutDSel=10, Mem_CS=0, DR_E=1. DR_FunSel=01 in T3 and 10 in T4..T6.
  - T3..T5: AR++ (ARF_RegSel=010, ARF_FunSel=01).
  - T7: MuxASel=10, Rx <= DR. Next step is T0.
- Opcode 0x14 ADD, at T2:
  - RF_OutASel=RSel, RF_OutBSel=000, ALU_FunSel=10100, ALU_WF=1.
  - MuxASel=00, Rx <= Rx + R1. Next step is T0.
- Opcode 0x15 HLT, at T2: Halted <= 1 and SeqCnt <= 0. While halted, all outputs are idle and SeqCnt stays 0.
- Any other opcode is a NOP: T2 with idle outputs, then T0.

## Timing
- Reset asserted gives SeqCnt=0 and Halted=0 immediately, with no clock needed.
- While Reset is asserted, outputs are forced idle, including during T0.
- The first fetch step is the first rising edge after Reset deasserts.
- Instruction latency in cycles:
  - BRA, MOVL, ADD, NOP: 3.
  - LD: 8.
  - HLT: 3, then stopped.
- Memory read is combinational: the address is driven in Tn and the byte is captured by IR or DR at the end of Tn.
- PC advances by exactly 2 per instruction, except BRA, which overrides PC at T2.
- PC and AR wrap 0xFFFF -> 0x0000 inside the ARF; the sequencer does not check for wrap.
- Reset mid-instruction (for example during LD at T5) aborts the instruction and returns to T0.
  - Partially written DR, AR and PC are left as they are.
  - Rx is not written.
- The counter wraps T7 -> T0 only through LD completion. No other opcode reaches T3.

## Test plan
- Reset, then mem[0..1]=5A,45 (MOVL R2,0x5A) -> T0 increments PC to 1, T1 to 2, IR=0x455A; R2=0x0000005A after T2; SeqCnt=0.
- mem[0..1]=20,00 (BRA 0x20), then HLT at 0x20 (00,54) -> PC=0x0020 after cycle 3; Halted=1 after cycle 6; outputs stay idle for 20 further cycles.
- LD R1,0x40 (mem 40,48) with mem[0x40..0x43]=11,22,33,44 -> R1=0x11223344 at the end of T7; AR=0x0043; 8 cycles total.
- R3=0x7FFFFFFF, R1=1, ADD R3 (00,52) -> R3=0x80000000; ALU_WF=1 only in T2.
- Reset pulsed low during LD T5 -> SeqCnt=0 asynchronously; R1 unchanged; the next fetch reads from the current PC.
- Undefined opcode 0x3F (00,FC) -> 3 cycles, no register or memory change, PC += 2.
